// File: rtl/edge_detector_multi_if.sv
// Channel-side bundle of edge_detector_multi: control inputs and detector outputs.
// The bench or register bank drives the master modport; the detector owns the slave modport.
interface edge_detector_multi_if #(
    parameter int CH     = 4,
    parameter int FILT_W = 4,
    parameter int CNT_W  = 16
) ();
    logic                  enable;
    logic [CH-1:0]         din;
    logic [2*CH-1:0]       mode;
    logic [FILT_W-1:0]     filt_len;
    logic [CH-1:0]         clr;
    logic [CH-1:0]         dout;
    logic [CH-1:0]         level;
    logic [CH-1:0]         sticky;
    logic [CH*CNT_W-1:0]   count;

    modport master (
        output enable, din, mode, filt_len, clr,
        input  dout, level, sticky, count
    );

    modport slave (
        input  enable, din, mode, filt_len, clr,
        output dout, level, sticky, count
    );
endinterface

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector with a synchroniser chain, a glitch filter, edge
// selection, sticky flags and saturating event counters.
module edge_detector_multi #(
    parameter int CH     = 4,
    parameter int SYNC   = 2,
    parameter int FILT_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    edge_detector_multi_if.slave bus
);
    logic [SYNC-1:0][CH-1:0]   sync_q;
    logic [CH-1:0]             s;
    logic [CH-1:0][FILT_W-1:0] fcnt_q, fcnt_d;
    logic [CH-1:0]             level_q, level_d;
    logic [CH-1:0]             ev;
    logic [CH-1:0]             hit;
    logic [CH-1:0]             dout_q;
    logic [CH-1:0]             sticky_q, sticky_d;
    logic [CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;

    assign s = sync_q[SYNC-1];

    always_comb begin
        level_d  = level_q;
        fcnt_d   = '0;
        ev       = '0;
        hit      = '0;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < CH; i++) begin
            // >= lets a lowered filter length release a change already pending
            if (s[i] != level_q[i]) begin
                if (fcnt_q[i] >= bus.filt_len) begin
                    level_d[i] = s[i];
                    ev[i]      = 1'b1;
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FILT_W'(1);
                end
            end
            hit[i] = ev[i] & bus.enable &
                     ((bus.mode[2*i] & s[i]) | (bus.mode[2*i+1] & ~s[i]));
            sticky_d[i] = (sticky_q[i] & ~bus.clr[i]) | hit[i];
            if (bus.clr[i]) begin
                cnt_d[i] = hit[i] ? CNT_W'(1) : '0;
            end else if (hit[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            fcnt_q   <= '0;
            level_q  <= '0;
            dout_q   <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC-2:0], bus.din};
            fcnt_q   <= fcnt_d;
            level_q  <= level_d;
            dout_q   <= hit;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.level  = level_q;
    assign bus.sticky = sticky_q;
    assign bus.count  = cnt_q;
endmodule
